// File: rtl/dshot_pkg.sv
// Shared constants, state encoding and CRC helper for the DShot transmitter.
package dshot_pkg;

    localparam int DSHOT_MIN_THROTTLE = 48;
    localparam int DSHOT_RANGE        = 1999;
    localparam int DSHOT_FRAME_BITS   = 16;
    localparam int Q_FRAC_BITS        = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } dshot_state_t;

    // XOR of the three nibbles of the 12-bit payload.
    function automatic logic [3:0] dshot_crc(input logic [11:0] p12);
        return p12[3:0] ^ p12[7:4] ^ p12[11:8];
    endfunction

endpackage

// File: rtl/dshot_frame_builder.sv
// Maps Q4.28 throttle to an 11-bit DShot value and appends telemetry bit and CRC.
// DSHOT_TX_BIDIR_EN selects the inverted CRC used by bidirectional DShot.
module dshot_frame_builder
    import dshot_pkg::*;
(
    input  logic signed [31:0] i_throttle,
    input  logic               i_telemetry,
    output logic [15:0]        o_frame
);

    localparam logic signed [31:0] ONE_Q = 32'sd1 <<< Q_FRAC_BITS;

    logic                   w_zero;
    logic [Q_FRAC_BITS:0]   w_clamped;
    logic [39:0]            w_product;
    logic [10:0]            w_value;
    logic [11:0]            w_p12;
    logic [3:0]             w_crc;

    always_comb begin
        w_zero    = 1'b0;
        w_clamped = '0;
        if (i_throttle <= 32'sd0) begin
            w_zero = 1'b1;
        end else if (i_throttle >= ONE_Q) begin
            w_clamped = (Q_FRAC_BITS + 1)'(ONE_Q);
        end else begin
            w_clamped = (Q_FRAC_BITS + 1)'(i_throttle);
        end
    end

    // Product stays below 2^39, so the shift truncates toward zero.
    assign w_product = 40'(w_clamped) * 40'(DSHOT_RANGE);
    assign w_value   = w_zero ? 11'd0
                              : 11'(DSHOT_MIN_THROTTLE) + 11'(w_product >> Q_FRAC_BITS);
    assign w_p12     = {w_value, i_telemetry};

`ifdef DSHOT_TX_BIDIR_EN
    assign w_crc = ~dshot_crc(w_p12);
`else
    assign w_crc = dshot_crc(w_p12);
`endif

    assign o_frame = {w_p12, w_crc};

endmodule

// File: rtl/dshot_tx.sv
// DShot transmitter: accepts one throttle value, serialises a 16-bit frame MSB first, then idles.
// DSHOT_TX_BIDIR_EN inverts the line (idle high, low-going pulses).
module dshot_tx
    import dshot_pkg::*;
#(
    parameter int BIT_CLKS = 80,
    parameter int T1H_CLKS = 60,
    parameter int T0H_CLKS = 30,
    parameter int GAP_CLKS = 96
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [31:0] mixedThrottle,
    input  logic               telemetry_req,
    input  logic               valid,
    output logic               ready,
    output logic               motor_out,
    output logic               busy,
    output logic [15:0]        frame_dbg,
    output logic [1:0]         state_dbg
);

    // Handshake: a value transfers on a clk edge where valid && ready; ready is high only
    // in IDLE, and a producer seeing ready low must hold its value until it is accepted.

    localparam int CNT_MAX = (BIT_CLKS > GAP_CLKS) ? BIT_CLKS : GAP_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_GAP  = GAP;

`ifdef DSHOT_TX_BIDIR_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_idx;
    logic [15:0]      r_shift;
    logic [15:0]      r_frame_dbg;
    logic             r_motor;

    logic [15:0]      w_frame;
    logic             w_accept;
    logic [1:0]       w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [3:0]       w_nxt_idx;
    logic [15:0]      w_nxt_shift;
    logic             w_nxt_high;

    dshot_frame_builder u_builder (
        .i_throttle  (mixedThrottle),
        .i_telemetry (telemetry_req),
        .o_frame     (w_frame)
    );

    assign w_accept = valid && (r_state == ST_IDLE);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_idx   = r_bit_idx;
        w_nxt_shift = r_shift;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nxt_state = ST_SEND;
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = 4'(DSHOT_FRAME_BITS - 1);
                    w_nxt_shift = w_frame;
                end
            end
            ST_SEND: begin
                if (r_cnt == CNT_W'(BIT_CLKS - 1)) begin
                    w_nxt_cnt = '0;
                    if (r_bit_idx == 4'd0) begin
                        w_nxt_state = ST_GAP;
                    end else begin
                        w_nxt_idx   = r_bit_idx - 4'd1;
                        w_nxt_shift = {r_shift[14:0], 1'b0};
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(GAP_CLKS - 1)) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
        // Line level is registered from the next-state view so the pad sees no comparator glitches.
        w_nxt_high = (w_nxt_state == ST_SEND) &&
                     (w_nxt_cnt < (w_nxt_shift[15] ? CNT_W'(T1H_CLKS) : CNT_W'(T0H_CLKS)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_dbg <= '0;
            r_motor     <= IDLE_LVL;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_bit_idx <= w_nxt_idx;
            r_shift   <= w_nxt_shift;
            r_motor   <= w_nxt_high ? ~IDLE_LVL : IDLE_LVL;
            if (w_accept) begin
                r_frame_dbg <= w_frame;
            end
        end
    end

    assert property (@(posedge clk)
        (T0H_CLKS < T1H_CLKS) && (T1H_CLKS < BIT_CLKS) && (GAP_CLKS >= 1));

    assign ready     = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign motor_out = r_motor;
    assign frame_dbg = r_frame_dbg;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_dshot_tx.sv
// Directed bench for dshot_tx: frame contents, pulse widths, gap timing, back-pressure and reset.
`timescale 1ns/1ps
module tb_dshot_tx;

`ifdef DSHOT_TX_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif
    localparam logic IDLE_LVL = BIDIR;
    localparam logic ACT_LVL  = ~BIDIR;
    localparam int   ACCEPT_TO_READY = 16 * 80 + 96;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [31:0] thr_in = '0;
    logic               tlm_in = 1'b0;
    logic               valid_in = 1'b0;
    logic               ready;
    logic               motor_out;
    logic               busy;
    logic [15:0]        frame_dbg;
    logic [1:0]         state_dbg;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    logic signed [31:0] vt_thr[4];
    logic               vt_tlm[4];
    logic [15:0]        vt_exp[4];

    dshot_tx dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mixedThrottle (thr_in),
        .telemetry_req (tlm_in),
        .valid         (valid_in),
        .ready         (ready),
        .motor_out     (motor_out),
        .busy          (busy),
        .frame_dbg     (frame_dbg),
        .state_dbg     (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] fsel(input logic [15:0] plain, input logic [15:0] bidir);
        return BIDIR ? bidir : plain;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s ready_wait", tag), 32'(ready === 1'b1), 32'd1);
    endtask

    // Follows a frame from the first cycle after accept through the gap.
    task automatic watch_frame(input string tag, input logic [15:0] exp);
        int lead, total, k, gap_act;
        bit still;
        for (int b = 15; b >= 0; b--) begin
            lead = 0; total = 0; still = 1'b1;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (motor_out === ACT_LVL) begin
                    total++;
                    if (still) lead++;
                end else begin
                    still = 1'b0;
                end
            end
            check($sformatf("%s bit%0d pulse", tag, b),
                  32'((total << 8) | lead), exp[b] ? 32'((60 << 8) | 60) : 32'((30 << 8) | 30));
        end
        k = 1280; gap_act = 0;
        while (ready !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
            if (motor_out !== IDLE_LVL) gap_act++;
        end
        check($sformatf("%s ready_latency", tag), 32'(k - 1), 32'(ACCEPT_TO_READY));
        check($sformatf("%s gap_idle", tag), 32'(gap_act), 32'd0);
        check($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
    endtask

    task automatic do_frame(input string tag, input logic signed [31:0] thr, input logic tlm,
                            input logic [15:0] exp);
        wait_ready(tag);
        thr_in = thr; tlm_in = tlm; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check($sformatf("%s frame_dbg", tag), 32'(frame_dbg), 32'(exp));
        check($sformatf("%s busy", tag), 32'(busy), 32'd1);
        check($sformatf("%s ready_low", tag), 32'(ready), 32'd0);
        watch_frame(tag, exp);
    endtask

    initial begin
        int cyc, accepts, last_acc, short_gap, stale, j;
        logic [15:0] last_exp, e;

        vt_thr[0] = 32'sh0800_0000; vt_tlm[0] = 1'b0; vt_exp[0] = fsel(16'h82E4, 16'h82EB);
        vt_thr[1] = 32'sh0400_0000; vt_tlm[1] = 1'b1; vt_exp[1] = fsel(16'h4477, 16'h4478);
        vt_thr[2] = 32'sh0000_0001; vt_tlm[2] = 1'b0; vt_exp[2] = fsel(16'h0606, 16'h0609);
        vt_thr[3] = 32'sh0FFF_FFFF; vt_tlm[3] = 1'b0; vt_exp[3] = fsel(16'hFFCC, 16'hFFC3);

        // Reset state
        #1;
        check("reset motor_out", 32'(motor_out), 32'(IDLE_LVL));
        check("reset ready", 32'(ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_dbg", 32'(frame_dbg), 32'd0);
        check("reset state", 32'(state_dbg), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_frame("half",      32'sh0800_0000, 1'b0, fsel(16'h82E4, 16'h82EB));
        do_frame("one",       32'sh1000_0000, 1'b0, fsel(16'hFFEE, 16'hFFE1));
        do_frame("max",       32'sh7FFF_FFFF, 1'b0, fsel(16'hFFEE, 16'hFFE1));
        do_frame("over_one",  32'sh1000_0001, 1'b0, fsel(16'hFFEE, 16'hFFE1));
        do_frame("neg5",      -32'sd5,        1'b0, fsel(16'h0000, 16'h000F));
        do_frame("zero",      32'sh0000_0000, 1'b0, fsel(16'h0000, 16'h000F));
        do_frame("zero_tlm",  32'sh0000_0000, 1'b1, fsel(16'h0011, 16'h001E));
        do_frame("quarter_t", 32'sh0400_0000, 1'b1, fsel(16'h4477, 16'h4478));
        do_frame("below_one", 32'sh0FFF_FFFF, 1'b0, fsel(16'hFFCC, 16'hFFC3));

        // Valid held high with the value changing every cycle
        wait_ready("stream");
        exp_q.delete();
        valid_in = 1'b1; cyc = 0; accepts = 0; last_acc = -1; short_gap = 0; stale = 0;
        last_exp = '0;
        while (accepts < 3 && cyc < 6000) begin
            j = cyc % 4;
            thr_in = vt_thr[j]; tlm_in = vt_tlm[j];
            if (ready === 1'b1) begin
                exp_q.push_back(vt_exp[j]);
                accepts++;
                if (last_acc >= 0 && (cyc - last_acc) < ACCEPT_TO_READY + 1) short_gap++;
                last_acc = cyc;
            end
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("stream frame%0d", accepts), 32'(frame_dbg), 32'(e));
                check($sformatf("stream busy%0d", accepts), 32'(ready), 32'd0);
                last_exp = e;
            end else if (busy === 1'b1 && frame_dbg !== last_exp) begin
                stale++;
            end
        end
        valid_in = 1'b0;
        check("stream accepts", 32'(accepts), 32'd3);
        check("stream spacing", 32'(short_gap), 32'd0);
        check("stream held", 32'(stale), 32'd0);

        // Reset during bit 7 of a frame
        wait_ready("rst");
        thr_in = 32'sh0800_0000; tlm_in = 1'b0; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (650) @(negedge clk);
        check("rst pre bit7 active", 32'(motor_out), 32'(ACT_LVL));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst motor idle", 32'(motor_out), 32'(IDLE_LVL));
        check("rst ready", 32'(ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst frame_dbg", 32'(frame_dbg), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst ready after", 32'(ready), 32'd1);
        do_frame("post_rst", 32'sh1000_0000, 1'b0, fsel(16'hFFEE, 16'hFFE1));

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
